// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN datapath blocks.
package cnn_pkg;
  localparam int ACT_W = 8;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_TAP0 = 2'b01;
  localparam logic [1:0] SEL_TAP1 = 2'b10;
  localparam logic [1:0] SEL_TAP2 = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} seq_state_t;
  function automatic logic [1:0] tap_sel(input logic [1:0] tap);
    return tap == 2'd0 ? SEL_TAP0 : tap == 2'd1 ? SEL_TAP1 : SEL_TAP2;
  endfunction
endpackage

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-deep issue-valid shift register; its tail bit is the product sample strobe.
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic strobe_o,
  output logic empty_next_o
);
  logic [DEPTH-1:0] sr_q, sr_d;
  assign sr_d         = DEPTH'({sr_q, d_i});
  assign strobe_o     = sr_q[DEPTH-1];
  assign empty_next_o = ~|sr_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
endmodule

// File: rtl/conv3_mac_seq.sv
// conv3_mac_seq: issues the three taps of a window to the shared multiplier mux
// and accumulates the returned products into the window sum.
module conv3_mac_seq
  import cnn_pkg::*;
#(
  parameter int ACC_W    = 10,
  parameter int PROD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACT_W-1:0] in_a0,
  input  logic [ACT_W-1:0] in_a1,
  input  logic [ACT_W-1:0] in_a2,
  input  logic [ACT_W-1:0] in_k0,
  input  logic [ACT_W-1:0] in_k1,
  input  logic [ACT_W-1:0] in_k2,
  output logic [1:0]       mult_sel,
  output logic [ACT_W-1:0] mult_a0,
  output logic [ACT_W-1:0] mult_a1,
  output logic [ACT_W-1:0] mult_a2,
  output logic [ACT_W-1:0] mult_k0,
  output logic [ACT_W-1:0] mult_k1,
  output logic [ACT_W-1:0] mult_k2,
  input  logic [ACT_W-1:0] mult_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);
  seq_state_t state_q, state_d;
  logic [1:0] tap_q, tap_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0][ACT_W-1:0] a_q, k_q;
  logic issue, accept, strobe, drained;
  assign issue     = state_q == ST_ISSUE;
  assign in_ready  = state_q == ST_IDLE || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign mult_sel  = issue ? tap_sel(tap_q) : SEL_NONE;
  assign out_valid = state_q == ST_DONE;
  assign out_sum   = acc_q;
  assign {mult_a2, mult_a1, mult_a0} = a_q;
  assign {mult_k2, mult_k1, mult_k0} = k_q;
  valid_delay #(.DEPTH(PROD_LAT)) u_valid_delay (
    .clk          (clk),
    .rst          (rst),
    .d_i          (issue),
    .strobe_o     (strobe),
    .empty_next_o (drained)
  );
  // DONE hands straight over to ISSUE when the next window is waiting.
  always_comb begin
    state_d = state_q;
    tap_d   = issue ? tap_q + 2'd1 : tap_q;
    acc_d   = strobe ? acc_q + ACC_W'(mult_product) : acc_q;
    unique case (state_q)
      ST_ISSUE: state_d = tap_q == 2'd2 ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_d = drained ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = out_ready ? (in_valid ? ST_ISSUE : ST_IDLE) : ST_DONE;
      default:  state_d = in_valid ? ST_ISSUE : ST_IDLE;
    endcase
    if (accept) begin
      tap_d = '0;
      acc_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q <= {in_a2, in_a1, in_a0};
        k_q <= {in_k2, in_k1, in_k0};
      end
    end
endmodule

// File: tb/tb_conv3_mac_seq.sv
// tb_conv3_mac_seq: scoreboard bench running the sequencer at PROD_LAT 1 and 3,
// each against a behavioural multiplier mux ((a*k)>>1, 8 bits).
module tb_conv3_mac_seq;
  logic clk = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mp(input logic [7:0] a, input logic [7:0] k);
    logic [15:0] t;
    t = a * k;
    return t[8:1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int LAT = g == 0 ? 1 : 3;
    logic rst, iv, in_ready, out_valid, out_ready, dr, rr, rnd;
    logic [2:0][7:0] ia, ik, ma, mk;
    logic [1:0] msel;
    logic [7:0] prod, sel_p;
    logic [7:0] pr [LAT];
    logic [9:0] osum;
    int exp_q[$];
    int tacc_q[$];
    bit done_f = 0;

    assign out_ready = rr ? rnd : dr;
    always @(posedge clk) rnd <= 1'($urandom);

    conv3_mac_seq #(.ACC_W(10), .PROD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_ready),
      .in_a0(ia[0]), .in_a1(ia[1]), .in_a2(ia[2]),
      .in_k0(ik[0]), .in_k1(ik[1]), .in_k2(ik[2]),
      .mult_sel(msel),
      .mult_a0(ma[0]), .mult_a1(ma[1]), .mult_a2(ma[2]),
      .mult_k0(mk[0]), .mult_k1(mk[1]), .mult_k2(mk[2]),
      .mult_product(prod), .out_valid(out_valid), .out_ready(out_ready), .out_sum(osum)
    );

    // Registered mux with LAT-1 extra delay stages; holds its product while sel is 00.
    assign sel_p = msel == 2'd1 ? mp(ma[0], mk[0]) : msel == 2'd2 ? mp(ma[1], mk[1]) : mp(ma[2], mk[2]);
    always @(posedge clk) begin
      if (msel != 2'd0) pr[0] <= sel_p;
      for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
    end
    assign prod = pr[LAT-1];

    task automatic send(input logic [7:0] a0, a1, a2, k0, k1, k2);
      int t = 0;
      iv = 1;
      ia = {a2, a1, a0};
      ik = {k2, k1, k0};
      #1;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk($sformatf("L%0d accept", LAT), int'(in_ready), 1);
      exp_q.push_back(int'(mp(a0, k0)) + int'(mp(a1, k1)) + int'(mp(a2, k2)));
      tacc_q.push_back(cyc);
      @(negedge clk);
      iv = 0;
      ia = 24'($urandom);
      ik = 24'($urandom);
    endtask

    task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      #2;
      chk($sformatf("L%0d drain", LAT), exp_q.size(), 0);
    endtask

    initial begin : mon
      bit pv = 0;
      bit ph = 0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
          pv = 0;
          ph = 0;
        end else begin
          if (out_valid) begin
            if (exp_q.size() == 0) chk($sformatf("L%0d spurious out_valid", LAT), int'(out_valid), 0);
            else begin
              chk($sformatf("L%0d sum", LAT), int'(osum), exp_q[0]);
              if (!pv || ph) chk($sformatf("L%0d latency", LAT), cyc - tacc_q[0], 4 + LAT);
              if (out_ready) begin
                void'(exp_q.pop_front());
                void'(tacc_q.pop_front());
              end
            end
          end
          pv = out_valid;
          ph = out_valid && out_ready;
        end
      end
    end

    initial begin : drv
      rst = 0; iv = 0; dr = 1; rr = 0; ia = '0; ik = '0;
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("L%0d rst in_ready", LAT), int'(in_ready), 1);
      chk($sformatf("L%0d rst out_valid", LAT), int'(out_valid), 0);
      chk($sformatf("L%0d rst out_sum", LAT), int'(osum), 0);
      chk($sformatf("L%0d rst mult_sel", LAT), int'(msel), 0);
      chk($sformatf("L%0d rst operands", LAT), int'(|{ma, mk}), 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      send(10, 20, 30, 2, 3, 4);
      for (int s = 1; s <= 4; s++) begin
        chk($sformatf("L%0d sel step %0d", LAT, s), int'(msel), s % 4);
        @(negedge clk);
      end
      wait_drain();
      send(16, 16, 16, 31, 31, 31);
      send(255, 255, 255, 1, 1, 1);
      wait_drain();
      dr = 0;
      send(7, 8, 9, 100, 110, 120);
      for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk($sformatf("L%0d hold in_ready", LAT), int'(in_ready), 0);
      dr = 1;
      send(200, 150, 99, 5, 6, 7);
      wait_drain();
      send(1, 2, 3, 4, 5, 6);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("L%0d sel before reset", LAT), int'(msel), 3);
      rst = 0;
      #1;
      chk($sformatf("L%0d abort mult_sel", LAT), int'(msel), 0);
      chk($sformatf("L%0d abort out_valid", LAT), int'(out_valid), 0);
      chk($sformatf("L%0d abort in_ready", LAT), int'(in_ready), 1);
      exp_q.delete();
      tacc_q.delete();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      send(9, 9, 9, 9, 9, 9);
      wait_drain();
      rr = 1;
      repeat (40) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      rr = 0;
      dr = 1;
      wait_drain();
      done_f = 1;
    end
  end

  initial begin
    int t = 0;
    while (!(h[0].done_f && h[1].done_f) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("finish", int'(h[0].done_f && h[1].done_f), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
